// File: rtl/inst_cache_pkg.sv
// Shared types and default widths for the direct-mapped instruction cache.
// Optional perf counters are enabled by defining ICACHE_PERF_EN.
package inst_cache_pkg;

  localparam int IC_ADDR_W  = 32;
  localparam int IC_DATA_W  = 32;
  localparam int IC_INDEX_W = 6;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_MISS = 1'b1
  } ic_state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and ram_controller-side signals of the instruction cache.
// slave is the cache view; master is the fetch stage plus memory.
interface inst_cache_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  if_en_in;
  logic [ADDR_WIDTH-1:0] if_addr_in;
  logic                  if_clr_in;
  logic                  if_rdy_out;
  logic [DATA_WIDTH-1:0] if_inst_out;
  logic                  mem_en_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  mem_rdy_in;
  logic [DATA_WIDTH-1:0] mem_inst_in;

  modport slave (
    input  if_en_in,
    input  if_addr_in,
    input  if_clr_in,
    input  mem_rdy_in,
    input  mem_inst_in,
    output if_rdy_out,
    output if_inst_out,
    output mem_en_out,
    output mem_addr_out
  );

  modport master (
    output if_en_in,
    output if_addr_in,
    output if_clr_in,
    output mem_rdy_in,
    output mem_inst_in,
    input  if_rdy_out,
    input  if_inst_out,
    input  mem_en_out,
    input  mem_addr_out
  );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, synchronous write,
// synchronous clear of all valid bits on reset.
module icache_array #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 24,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  input  logic                   we_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk_i) begin
    if (!rst_i && we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped one-word-per-line instruction cache in front of ram_controller.
// Define ICACHE_PERF_EN to add perf_hit_out / perf_miss_out counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = IC_ADDR_W,
  parameter int DATA_WIDTH  = IC_DATA_W,
  parameter int INDEX_WIDTH = IC_INDEX_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  inst_cache_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_out,
  output logic [31:0] perf_miss_out
`endif
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

  ic_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  flush_q, flush_d;
  logic                  fill;

  logic [INDEX_WIDTH-1:0] rd_idx;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic                   line_valid;
  logic [TAG_WIDTH-1:0]   line_tag;
  logic [DATA_WIDTH-1:0]  line_data;
  logic                   req;
  logic                   hit;
  logic                   unused_addr_lsb;

  assign rd_idx = bus.if_addr_in[INDEX_WIDTH+1:2];
  assign rd_tag = bus.if_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_addr_lsb = ^bus.if_addr_in[1:0];

  assign req = (state_q == IC_IDLE) && bus.if_en_in && !bus.if_clr_in;
  assign hit = line_valid && (line_tag == rd_tag);

  icache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_array (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (line_valid),
    .rd_tag_o   (line_tag),
    .rd_data_o  (line_data),
    .we_i       (fill && rdy_in),
    .wr_idx_i   (maddr_q[INDEX_WIDTH+1:2]),
    .wr_tag_i   (maddr_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data_i  (bus.mem_inst_in)
  );

  // Dropped in the fill cycle so ram_controller never sees a second start.
  assign bus.mem_en_out   = (state_q == IC_MISS) && !bus.mem_rdy_in;
  assign bus.mem_addr_out = maddr_q;
  assign bus.if_rdy_out   = rdy_q;
  assign bus.if_inst_out  = inst_q;

  always_comb begin
    state_d = state_q;
    maddr_d = maddr_q;
    rdy_d   = 1'b0;
    inst_d  = inst_q;
    flush_d = flush_q;
    fill    = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        if (req && hit) begin
          rdy_d  = 1'b1;
          inst_d = line_data;
        end else if (req) begin
          maddr_d = {bus.if_addr_in[ADDR_WIDTH-1:2], 2'b00};
          state_d = IC_MISS;
        end
      end
      IC_MISS: begin
        if (bus.if_clr_in) flush_d = 1'b1;
        if (bus.mem_rdy_in) begin
          fill    = 1'b1;
          flush_d = 1'b0;
          state_d = IC_IDLE;
          if (!flush_q && !bus.if_clr_in) begin
            rdy_d  = 1'b1;
            inst_d = bus.mem_inst_in;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IC_IDLE;
      maddr_q <= '0;
      rdy_q   <= 1'b0;
      inst_q  <= '0;
      flush_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      rdy_q   <= rdy_d;
      inst_q  <= inst_d;
      flush_q <= flush_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in) begin
      if (req && hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (req && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_out  = hit_cnt_q;
  assign perf_miss_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench for inst_cache against a line-map reference model
// and a 5-cycle behavioural ram_controller.
module tb_inst_cache;

  logic clk;
  logic rst;
  logic rdy;

  inst_cache_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  inst_cache dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus.slave)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit_out  (perf_hit),
    .perf_miss_out (perf_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural ram_controller: answers after 5 cycles of inst_en.
  int ram_cnt = 0;
  int reads   = 0;
  int en_cyc  = 0;

  always @(posedge clk) begin
    if (rst) begin
      ram_cnt <= 0;
      bus.mem_rdy_in <= 1'b0;
    end else if (rdy) begin
      if (bus.mem_rdy_in) begin
        bus.mem_rdy_in <= 1'b0;
      end else if (bus.mem_en_out) begin
        if (ram_cnt == 4) begin
          bus.mem_rdy_in  <= 1'b1;
          bus.mem_inst_in <= mem_word(bus.mem_addr_out);
          ram_cnt <= 0;
          reads   <= reads + 1;
        end else begin
          ram_cnt <= ram_cnt + 1;
        end
      end
    end
  end

  logic [31:0] cur_addr;

  always @(negedge clk) begin
    if (!rst && bus.mem_rdy_in)
      chk("mem_en_in_rdy_cycle", {31'd0, bus.mem_en_out}, 32'd0);
    if (!rst && bus.mem_en_out) begin
      en_cyc++;
      chk("mem_addr", bus.mem_addr_out, cur_addr);
    end
  end

  // Reference: which word address each index currently holds.
  logic [31:0] line_of [int];
  int m_hits   = 0;
  int m_misses = 0;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 64);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i = idx_of(a);
    return line_of.exists(i) && line_of[i] == {a[31:2], 2'b00};
  endfunction

  task automatic do_fetch(input logic [31:0] a, input int stall_at,
                          input int clr_at);
    bit          exp_hit;
    bit          got;
    int          n;
    int          r0;
    int          e0;
    logic [31:0] data;
    exp_hit  = model_hit(a);
    r0       = reads;
    e0       = en_cyc;
    got      = 0;
    n        = 0;
    data     = '0;
    cur_addr = {a[31:2], 2'b00};
    bus.if_en_in   = 1'b1;
    bus.if_addr_in = a;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.if_rdy_out) begin
        got  = 1;
        data = bus.if_inst_out;
        bus.if_en_in = 1'b0;
        break;
      end
      bus.if_clr_in = 1'b0;
      if (clr_at > 0 && n == clr_at) begin
        bus.if_clr_in = 1'b1;
        bus.if_en_in  = 1'b0;
      end
      if (stall_at > 0 && n == stall_at) rdy = 1'b0;
      if (stall_at > 0 && n == stall_at + 3) rdy = 1'b1;
      if (clr_at > 0 && n >= 14) break;
    end
    bus.if_en_in  = 1'b0;
    bus.if_clr_in = 1'b0;
    if (clr_at > 0) begin
      chk("flush_no_rdy", {31'd0, got}, 32'd0);
    end else begin
      chk("served", {31'd0, got}, 32'd1);
      chk("data", data, mem_word({a[31:2], 2'b00}));
      chk("latency", n, exp_hit ? 1 : (stall_at > 0 ? 10 : 7));
    end
    chk("ram_reads", reads - r0, exp_hit ? 0 : 1);
    chk("en_cycles", en_cyc - e0,
        exp_hit ? 0 : (stall_at > 0 ? 8 : 5));
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      line_of[idx_of(a)] = {a[31:2], 2'b00};
    end
    @(negedge clk);
    chk("rdy_pulse", {31'd0, bus.if_rdy_out}, 32'd0);
  endtask

  task automatic idle_clr(input logic [31:0] a);
    bit seen = 0;
    int r0   = reads;
    bus.if_en_in   = 1'b1;
    bus.if_clr_in  = 1'b1;
    bus.if_addr_in = a;
    @(negedge clk);
    bus.if_en_in  = 1'b0;
    bus.if_clr_in = 1'b0;
    repeat (10) begin
      if (bus.if_rdy_out) seen = 1;
      @(negedge clk);
    end
    chk("idle_clr_no_rdy", {31'd0, seen}, 32'd0);
    chk("idle_clr_reads", reads - r0, 0);
  endtask

  task automatic rst_mid_miss(input logic [31:0] a);
    int r0 = reads;
    cur_addr = {a[31:2], 2'b00};
    bus.if_en_in   = 1'b1;
    bus.if_addr_in = a;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.if_en_in = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
    chk("rst_if_rdy", {31'd0, bus.if_rdy_out}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_out, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_reads", reads - r0, 0);
    line_of.delete();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic chk_perf();
`ifdef ICACHE_PERF_EN
    chk("perf_hit", perf_hit, m_hits);
    chk("perf_miss", perf_miss, m_misses);
`endif
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    bus.if_en_in    = 1'b0;
    bus.if_addr_in  = '0;
    bus.if_clr_in   = 1'b0;
    bus.mem_inst_in = '0;
    cur_addr = '0;
    rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_if_rdy", {31'd0, bus.if_rdy_out}, 32'd0);
    chk("reset_mem_en", {31'd0, bus.mem_en_out}, 32'd0);
    chk("reset_inst", bus.if_inst_out, 32'd0);
    chk("reset_mem_addr", bus.mem_addr_out, 32'd0);

    do_fetch(32'h0000_0000, 0, 0);
    do_fetch(32'h0000_0000, 0, 0);
    do_fetch(32'h0000_0100, 0, 0);
    do_fetch(32'h0000_0000, 0, 0);
    chk_perf();

    do_fetch(32'h0000_0200, 0, 2);
    do_fetch(32'h0000_0200, 0, 0);
    do_fetch(32'h0000_0300, 0, 6);
    do_fetch(32'h0000_0300, 0, 0);
    do_fetch(32'h0000_0404, 3, 0);
    do_fetch(32'h0000_0404, 0, 0);
    idle_clr(32'h0000_0008);
    do_fetch(32'h0000_0007, 0, 0);
    chk_perf();

    rst_mid_miss(32'h0000_0500);
    do_fetch(32'h0000_0000, 0, 0);

    for (int k = 0; k < 200; k++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 3'd0,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 9);
      if (!model_hit(a) && r == 0)
        do_fetch(a, 0, $urandom_range(1, 6));
      else if (!model_hit(a) && r == 1)
        do_fetch(a, $urandom_range(1, 5), 0);
      else if (r == 2)
        idle_clr(a);
      else
        do_fetch(a, 0, 0);
    end
    chk_perf();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
